// File: rtl/nibble_loader.sv
// nibble_loader: gathers NIBBLES 4-bit operands into a packed bus for an
// external adder tree. Once the bus is full it is held for SETTLE cycles,
// the tree result is captured, and the sum is offered to a consumer with a
// valid/ready handshake.
module nibble_loader #(
  parameter int NIBBLES = 128,
  parameter int SETTLE  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic [3:0]             in_data,
  output logic                   in_ready,
  output logic [4*NIBBLES-1:0]   arr,
  input  logic [11:0]            tree_sum,
  output logic [11:0]            sum_out,
  output logic                   sum_valid,
  input  logic                   sum_ready,
  output logic [7:0]             count
);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_SETTLE,
    ST_HOLD
  } state_e;

  localparam logic [7:0] FULL        = 8'(NIBBLES);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_e                 state_q, state_d;
  logic [4*NIBBLES-1:0]   arr_q, arr_d;
  logic [7:0]             count_q, count_d;
  logic [3:0]             settleCnt_q, settleCnt_d;
  logic [11:0]            sumOut_q, sumOut_d;
  logic                   sumValid_q, sumValid_d;
  logic                   inReady_q, inReady_d;

  // State and datapath registers; reset wipes any partial frame or pending sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD;
      arr_q       <= '0;
      count_q     <= '0;
      settleCnt_q <= '0;
      sumOut_q    <= '0;
      sumValid_q  <= 1'b0;
      inReady_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      arr_q       <= arr_d;
      count_q     <= count_d;
      settleCnt_q <= settleCnt_d;
      sumOut_q    <= sumOut_d;
      sumValid_q  <= sumValid_d;
      inReady_q   <= inReady_d;
    end
  end

  // Next-state logic: clear overrides everything, otherwise load / settle / hold.
  always_comb begin
    state_d     = state_q;
    arr_d       = arr_q;
    count_d     = count_q;
    settleCnt_d = settleCnt_q;
    sumOut_d    = sumOut_q;
    sumValid_d  = sumValid_q;
    inReady_d   = inReady_q;

    if (clear) begin
      state_d     = ST_LOAD;
      arr_d       = '0;
      count_d     = '0;
      settleCnt_d = '0;
      sumValid_d  = 1'b0;
      inReady_d   = 1'b1;
    end else begin
      case (state_q)
        ST_LOAD: begin
          inReady_d = 1'b1;
          if (in_valid && inReady_q) begin
            for (int k = 0; k < NIBBLES; k++) begin
              if (count_q == 8'(k)) begin
                arr_d[4*k +: 4] = in_data;
              end
            end
            count_d = count_q + 8'd1;
            if (count_q == FULL - 8'd1) begin
              state_d     = ST_SETTLE;
              inReady_d   = 1'b0;
              settleCnt_d = '0;
            end
          end
        end
        ST_SETTLE: begin
          inReady_d = 1'b0;
          if (settleCnt_q == SETTLE_LAST) begin
            sumOut_d   = tree_sum;
            sumValid_d = 1'b1;
            state_d    = ST_HOLD;
          end else begin
            settleCnt_d = settleCnt_q + 4'd1;
          end
        end
        ST_HOLD: begin
          inReady_d = 1'b0;
          if (sum_ready) begin
            sumValid_d = 1'b0;
            arr_d      = '0;
            count_d    = '0;
            inReady_d  = 1'b1;
            state_d    = ST_LOAD;
          end
        end
        default: begin
          state_d = ST_LOAD;
        end
      endcase
    end
  end

  assign in_ready  = inReady_q;
  assign arr       = arr_q;
  assign count     = count_q;
  assign sum_out   = sumOut_q;
  assign sum_valid = sumValid_q;

endmodule

// File: doc/nibble_loader.md
NIBBLE_LOADER -- requirements
Module: nibble_loader

Interface
REQ-001 Parameter NIBBLES, 128, number of 4-bit operands packed per frame; the tree input width is 4*NIBBLES.
REQ-002 Parameter SETTLE, 1, number of cycles arr is held stable before the tree result is sampled; legal range 1..15.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 clear  input  1  synchronous frame flush, active-high.
REQ-006 in_valid  input  1  producer has a nibble on in_data.
REQ-007 in_data  input  4  unsigned operand nibble.
REQ-008 in_ready  output  1  registered; block accepts a nibble this cycle.
REQ-009 arr  output  4*NIBBLES  packed operand bus driven to the downstream adder tree.
REQ-010 tree_sum  input  12  combinational sum returned by the adder tree.
REQ-011 sum_out  output  12  registered frame sum.
REQ-012 sum_valid  output  1  sum_out holds a completed frame.
REQ-013 sum_ready  input  1  consumer accepts sum_out.
REQ-014 count  output  8  nibbles accepted in the current frame, 0..NIBBLES.

Function
REQ-015 The FSM SHALL have 3 states: LOAD, SETTLE, HOLD.
REQ-016 A nibble transfer SHALL occur only on a rising edge where in_valid=1 and in_ready=1.
REQ-017 In LOAD, in_ready=1, except during the first cycle after reset release.
REQ-018 Transfer k (k=0..NIBBLES-1, counted from frame start) SHALL be written to arr[4k+3:4k], with count incremented by 1.
REQ-019 Nibbles not yet written in a frame SHALL read 0 on arr.
REQ-020 On the transfer that makes count=NIBBLES, the FSM SHALL go to SETTLE and in_ready SHALL drop at that same edge.
REQ-021 In SETTLE, arr SHALL be held stable for exactly SETTLE cycles.
REQ-022 At the edge ending SETTLE, tree_sum SHALL be captured into sum_out, sum_valid SHALL be set to 1, and the FSM SHALL go to HOLD.
REQ-023 Latency: with the last nibble accepted at edge E, sum_valid rises at edge E+SETTLE.
REQ-024 In HOLD: in_ready=0; sum_out, sum_valid and arr SHALL remain stable; in_valid SHALL be ignored.
REQ-025 A HOLD edge with sum_ready=1 SHALL clear sum_valid, zero arr, zero count, set in_ready=1 and return the FSM to LOAD.
REQ-026 sum_ready SHALL be ignored outside HOLD.
REQ-027 sum_out SHALL keep its last value after the handshake until the next capture.
REQ-028 clear=1 SHALL have priority over every handshake at that edge: FSM to LOAD, arr=0, count=0, sum_valid=0, in_ready=1; any nibble presented that cycle is dropped.
REQ-029 No arithmetic is performed in-block; tree_sum is taken as 12-bit unsigned (maximum 1920 for NIBBLES=128).
REQ-030 count SHALL never exceed NIBBLES and SHALL never wrap.

Reset
REQ-031 rst_n=0 SHALL immediately, with no clock required, force: FSM=LOAD, arr=0, count=0, sum_out=0, sum_valid=0, in_ready=0.
REQ-032 in_ready SHALL rise at the first rising clk edge after rst_n deasserts.
REQ-033 Reset asserted mid-frame or in HOLD SHALL discard the partial frame or pending sum; no output glitches back to old data after release.

Verification
REQ-034 128 transfers of 0xF, sum_ready=1, SETTLE=1 -> sum_valid rises at edge E+1, sum_out=0x780 (1920), count=0 and in_ready=1 one edge later.
REQ-035 Transfer k carries k mod 16 -> arr[7:0]=0x10, arr[511:508]=0xF, sum_out=960.
REQ-036 sum_ready=0 for 10 cycles in HOLD with in_valid=1 -> sum_out and arr unchanged, in_ready=0, count=128; sum_ready=1 -> LOAD next edge.
REQ-037 clear at count=64, then 128 transfers of 0x1 -> count returns to 0 at the clear edge, arr=0, final sum_out=128.
REQ-038 rst_n pulsed low between clock edges at count=50 -> arr=0, count=0, in_ready=0 before the next edge; in_ready=1 at the first edge after release.
REQ-039 in_valid randomly toggled (~50%) over a full frame of 0x3 -> exactly 128 transfers counted, sum_out=384.
